// File: rtl/ball_sched_pkg.sv
// Shared types and constants for the ball movement scheduler.
package ball_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT_FRAME,
        ISSUE
    } sched_state_t;

    localparam int RIGHT = 3;
    localparam int LEFT  = 2;
    localparam int DOWN  = 1;
    localparam int UP    = 0;

    localparam int ACCEL_CENTER = 256;

    // Pressing both halves of an axis means "no intent" on that axis.
    function automatic logic [3:0] cancel_opposing(input logic [3:0] raw);
        logic [3:0] d;
        d = raw;
        if (raw[RIGHT] && raw[LEFT]) begin
            d[RIGHT] = 1'b0;
            d[LEFT]  = 1'b0;
        end
        if (raw[DOWN] && raw[UP]) begin
            d[DOWN] = 1'b0;
            d[UP]   = 1'b0;
        end
        return d;
    endfunction

endpackage

// File: rtl/ball_tick_gen.sv
// Step-rate divider: registered one-cycle tick every TICK_DIV clocks.
module ball_tick_gen #(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(TICK_DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/ball_move_sched.sv
// Ball movement scheduler: step pacing, autorepeat and frame-aligned move pulses.
// Define BALL_SCHED_ACCEL_EN to compile in the accelerometer direction source.
module ball_move_sched
    import ball_sched_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int STEP_HZ    = 60,
    parameter int HOLD_TICKS = 15,
    parameter int DEADZONE   = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_dir,
    input  logic       sel_accel,
    input  logic [8:0] accel_x,
    input  logic [8:0] accel_y,
    input  logic       frame_sync,
    output logic [3:0] move_out,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    localparam int TICK_DIV = CLK_HZ / STEP_HZ;
    localparam int HW       = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);

    logic          tick;
    logic [3:0]    raw_dir;
    logic [3:0]    dir;
    sched_state_t  state, state_nx;
    logic [3:0]    dir_q, dir_nx;
    logic [HW-1:0] hold_cnt, hold_nx;
    logic          drop_inc;

    ball_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

`ifdef BALL_SCHED_ACCEL_EN
    // Widened to 10 bits so the deadzone bounds never wrap.
    localparam logic [9:0] ACC_HI = 10'(ACCEL_CENTER + DEADZONE);
    localparam logic [9:0] ACC_LO = 10'(ACCEL_CENTER - DEADZONE);

    logic [3:0] accel_dir;

    always_comb begin
        accel_dir        = '0;
        accel_dir[RIGHT] = {1'b0, accel_x} > ACC_HI;
        accel_dir[LEFT]  = {1'b0, accel_x} < ACC_LO;
        accel_dir[DOWN]  = {1'b0, accel_y} > ACC_HI;
        accel_dir[UP]    = {1'b0, accel_y} < ACC_LO;
        raw_dir          = sel_accel ? accel_dir : btn_dir;
    end
`else
    logic unused_accel;
    assign unused_accel = ^{sel_accel, accel_x, accel_y};
    assign raw_dir      = btn_dir;
`endif

    assign dir = cancel_opposing(raw_dir);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            dir_q    <= '0;
            hold_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nx;
            dir_q    <= dir_nx;
            hold_cnt <= hold_nx;
            if (drop_inc && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    always_comb begin
        state_nx = state;
        dir_nx   = dir_q;
        hold_nx  = hold_cnt;
        drop_inc = 1'b0;
        case (state)
            IDLE: begin
                if (tick && dir != 4'd0) begin
                    dir_nx   = dir;
                    hold_nx  = '0;
                    state_nx = WAIT_FRAME;
                end
            end
            HOLD: begin
                if (tick) begin
                    if (dir == 4'd0) begin
                        state_nx = IDLE;
                    end else if (dir != dir_q) begin
                        dir_nx   = dir;
                        hold_nx  = '0;
                        state_nx = WAIT_FRAME;
                    end else if (hold_cnt < HW'(HOLD_TICKS)) begin
                        hold_nx  = hold_cnt + 1'b1;
                    end else begin
                        state_nx = WAIT_FRAME;
                    end
                end
            end
            WAIT_FRAME: begin
                // frame_sync takes priority over a coincident tick
                if (frame_sync) begin
                    state_nx = ISSUE;
                end else if (tick) begin
                    drop_inc = 1'b1;
                    if (dir == 4'd0)
                        state_nx = IDLE;
                    else
                        dir_nx = dir;
                end
            end
            ISSUE:   state_nx = HOLD;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        move_out = (state == ISSUE) ? dir_q : 4'd0;
        busy     = (state != IDLE);
    end

endmodule

// File: tb/tb_ball_move_sched.sv
// Self-checking bench for ball_move_sched (TICK_DIV=10, HOLD_TICKS=2).
module tb_ball_move_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_dir = 4'd0;
    logic       sel_accel = 1'b0;
    logic [8:0] accel_x = 9'd256;
    logic [8:0] accel_y = 9'd256;
    logic       frame_sync = 1'b0;
    logic [3:0] move_out;
    logic       busy;
    logic [7:0] drop_cnt;

    ball_move_sched #(
        .CLK_HZ(600), .STEP_HZ(60), .HOLD_TICKS(2), .DEADZONE(32)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .btn_dir    (btn_dir),
        .sel_accel  (sel_accel),
        .accel_x    (accel_x),
        .accel_y    (accel_y),
        .frame_sync (frame_sync),
        .move_out   (move_out),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edge counter since reset release, pending/active move bookkeeping.
    int         e = 0;
    bit         pending, active, issuing;
    logic [3:0] pend_dir = 4'd0, act_dir = 4'd0;
    int         held = 0, m_drop = 0, m_pulses = 0;

    function automatic logic [3:0] m_decode();
        logic [3:0] r;
        r = btn_dir;
`ifdef BALL_SCHED_ACCEL_EN
        if (sel_accel)
            r = {int'(accel_x) > 288, int'(accel_x) < 224, int'(accel_y) > 288, int'(accel_y) < 224};
`endif
        if (r[3] && r[2]) r[3:2] = 2'b00;
        if (r[1] && r[0]) r[1:0] = 2'b00;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e = 0; pending = 0; active = 0; issuing = 0;
            pend_dir = 0; act_dir = 0; held = 0; m_drop = 0;
        end else begin
            bit tk;
            logic [3:0] d;
            e = e + 1;
            tk = (e > 1) && ((e - 1) % 10 == 0);
            d = m_decode();
            if (issuing) begin
                issuing = 0; pending = 0; active = 1; act_dir = pend_dir;
            end else if (pending) begin
                if (frame_sync) issuing = 1;
                else if (tk) begin
                    if (m_drop < 255) m_drop++;
                    if (d == 0) pending = 0; else pend_dir = d;
                end
            end else if (active) begin
                if (tk) begin
                    if (d == 0) active = 0;
                    else if (d != act_dir) begin active = 0; pending = 1; pend_dir = d; held = 0; end
                    else if (held < 2) held++;
                    else begin active = 0; pending = 1; pend_dir = act_dir; end
                end
            end else if (tk && d != 0) begin
                pending = 1; pend_dir = d; held = 0;
            end
            if (issuing) m_pulses++;
        end
    end

    int         p_edge[$];
    logic [3:0] p_val[$];

    always @(negedge clk) begin
        if (rst_n) begin
            chk("move_out", 32'(move_out), issuing ? 32'(pend_dir) : 32'd0);
            chk("busy", 32'(busy), 32'(pending || active || issuing));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            if (move_out != 4'd0) begin
                p_edge.push_back(e);
                p_val.push_back(move_out);
            end
        end
    end

    task automatic wait_edge(input int n);
        while (e < n) begin
            @(posedge clk);
            #1;
        end
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0; frame_sync = 1'b0; btn_dir = 4'd0;
        sel_accel = 1'b0; accel_x = 9'd256; accel_y = 9'd256;
        #1;
        chk("rst_move_out", 32'(move_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        @(posedge clk); #2;
        p_edge.delete(); p_val.delete(); m_pulses = 0;
        rst_n = 1'b1;
    endtask

    task automatic chk_pulse(input string name, input int idx, input int edge_n, input logic [3:0] val);
        if (idx < p_edge.size()) begin
            chk({name, "_edge"}, 32'(p_edge[idx]), 32'(edge_n));
            chk({name, "_val"}, 32'(p_val[idx]), 32'(val));
        end else begin
            chk({name, "_missing"}, 32'(p_edge.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        // Idle after reset
        do_reset();
        wait_edge(100);
        chk("idle_pulses", 32'(p_edge.size()), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Single move, frame_sync three cycles after the first tick
        do_reset();
        btn_dir = 4'b0001;
        wait_edge(13); frame_sync = 1'b1;
        wait_edge(14); frame_sync = 1'b0;
        wait_edge(16); btn_dir = 4'b0000;
        wait_edge(30);
        chk("single_count", 32'(p_edge.size()), 32'd1);
        chk_pulse("single", 0, 14, 4'b0001);

        // Press then autorepeat with frame_sync every cycle
        do_reset();
        btn_dir = 4'b1000; frame_sync = 1'b1;
        wait_edge(65);
        chk("repeat_count", 32'(p_edge.size()), 32'd4);
        chk("repeat_model_count", 32'(m_pulses), 32'd4);
        chk_pulse("repeat0", 0, 12, 4'b1000);
        chk_pulse("repeat1", 1, 42, 4'b1000);
        chk_pulse("repeat2", 2, 52, 4'b1000);
        chk_pulse("repeat3", 3, 62, 4'b1000);

        // Opposing buttons cancel; diagonal passes
        do_reset();
        btn_dir = 4'b1100; frame_sync = 1'b1;
        wait_edge(35);
        chk("oppose_count", 32'(p_edge.size()), 32'd0);
        btn_dir = 4'b1001;
        wait_edge(45);
        chk("diag_count", 32'(p_edge.size()), 32'd1);
        chk_pulse("diag", 0, 42, 4'b1001);

        // No frame_sync across three ticks: two drops, latest dir issued
        do_reset();
        btn_dir = 4'b0001;
        wait_edge(25); btn_dir = 4'b0010;
        wait_edge(33);
        chk("drop_two", 32'(drop_cnt), 32'd2);
        frame_sync = 1'b1;
        wait_edge(34); frame_sync = 1'b0;
        wait_edge(36);
        chk("drop_count", 32'(p_edge.size()), 32'd1);
        chk_pulse("drop", 0, 34, 4'b0010);

        // Accelerometer source
        do_reset();
        sel_accel = 1'b1; frame_sync = 1'b1; accel_x = 9'd300;
        wait_edge(15); accel_x = 9'd288;
        wait_edge(25);
`ifdef BALL_SCHED_ACCEL_EN
        chk("accel_dz_count", 32'(p_edge.size()), 32'd1);
`else
        chk("accel_dz_count", 32'(p_edge.size()), 32'd0);
`endif
        accel_x = 9'd256; accel_y = 9'd200;
        wait_edge(35);
`ifdef BALL_SCHED_ACCEL_EN
        chk("accel_count", 32'(p_edge.size()), 32'd2);
        chk_pulse("accel_right", 0, 12, 4'b1000);
        chk_pulse("accel_up", 1, 32, 4'b0001);
`else
        chk("accel_count", 32'(p_edge.size()), 32'd0);
`endif

        // Reset during an ISSUE pulse
        do_reset();
        btn_dir = 4'b0100; frame_sync = 1'b1;
        wait_edge(12);
        chk("issue_live", 32'(move_out), 32'b0100);
        rst_n = 1'b0;
        #1;
        chk("midrst_move_out", 32'(move_out), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_drop", 32'(drop_cnt), 32'd0);

        // drop_cnt saturation
        do_reset();
        btn_dir = 4'b0001;
        wait_edge(11 + 10 * 258);
        chk("drop_sat", 32'(drop_cnt), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ball_move_sched.md
# ball_move_sched

Movement scheduler sitting between the input sources (debounced pushbuttons, optionally the accelerometer) and the `Ball` block's `movement[3:0]` port. It divides the 100 MHz clock into a step rate, samples the selected direction source on each step tick, and applies press-then-autorepeat pacing. It also aligns every move pulse to a frame-sync strobe from the VGA subsystem, so the ball never moves mid-frame. It replaces the ad-hoc tick/AND gating in the top level.

## Interface
- `CLK_HZ`, 100000000: system clock frequency.
- `STEP_HZ`, 60: step-tick rate; `TICK_DIV = CLK_HZ/STEP_HZ` (integer division, must be ≥ 2).
- `HOLD_TICKS`, 15: steps a direction must be held after the first move before autorepeat starts.
- `DEADZONE`, 32: accelerometer deadzone around center 256.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_dir`  in  4  debounced buttons `{right,left,down,up}`, level.
- `sel_accel`  in  1  1 = accelerometer is the source, 0 = buttons; sampled only on step ticks.
- `accel_x`, `accel_y`  in  9 each  unsigned, 256 = level.
- `frame_sync`  in  1  one-cycle strobe at frame start, from the VGA timing.
- `move_out`  out  4  `{right,left,down,up}`, one-cycle pulse, drives `Ball.movement`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `drop_cnt`  out  8  saturating count of moves replaced before they were issued.

## Operation
- Direction decode happens when a step tick arrives:
  - Buttons: raw = `btn_dir`.
  - Accelerometer:
    - right if `accel_x > 256+DEADZONE`; left if `accel_x < 256-DEADZONE`.
    - down if `accel_y > 256+DEADZONE`; up if `accel_y < 256-DEADZONE`.
    - Compare with 10-bit unsigned arithmetic; no wrap.
  - Opposing pair both set (right+left, or down+up): both bits are cleared. Diagonals are legal.
- States: IDLE, HOLD, WAIT_FRAME, ISSUE.
- IDLE:
  - tick with dir ≠ 0 → latch dir, clear `hold_cnt`, go to WAIT_FRAME.
  - tick with dir = 0 → stay in IDLE.
- HOLD (a direction was issued earlier):
  - tick with dir = 0 → IDLE.
  - tick with dir ≠ latched dir → latch the new dir, clear `hold_cnt`, go to WAIT_FRAME. This is an immediate first move.
  - tick with the same dir, `hold_cnt < HOLD_TICKS` → `hold_cnt`+1, stay in HOLD.
  - tick with the same dir, `hold_cnt == HOLD_TICKS` → WAIT_FRAME. This is autorepeat: one move per tick.
- WAIT_FRAME:
  - `frame_sync` → ISSUE.
  - A tick arriving before `frame_sync`: resample the direction.
    - dir = 0 → IDLE; `drop_cnt`+1.
    - otherwise → latch the new dir; `drop_cnt`+1.
  - `frame_sync` and tick in the same cycle: `frame_sync` wins. The old dir is issued and the tick is discarded, with no drop.
- ISSUE: `move_out` = latched dir for exactly one cycle, then go to HOLD.
- `drop_cnt` saturates at 255 and is cleared only by reset.

## Timing
- Reset values: `move_out`=0, `busy`=0, `drop_cnt`=0, state=IDLE, tick counter=0, `hold_cnt`=0, latched dir=0.
- Reset asserted mid-operation clears everything immediately, including an in-flight ISSUE pulse.
- Tick counter:
  - counts 0…TICK_DIV−1; the tick is a registered one-cycle pulse on wrap.
  - the first tick comes TICK_DIV cycles after reset deasserts.
- Latency:
  - `frame_sync` sampled in WAIT_FRAME at edge N → `move_out` high during cycle N+1 → low at N+2.
  - tick in IDLE → WAIT_FRAME on the next edge.
- `move_out` is registered; no combinational path from any input.
- `frame_sync` seen in IDLE or HOLD is ignored.

## Configuration
- `BALL_SCHED_ACCEL_EN`:
  - Defined: accelerometer decode is compiled in, and `sel_accel` chooses the source.
  - Undefined: the ports remain, but `accel_x`, `accel_y` and `sel_accel` are ignored and the source is always `btn_dir`.

## Structure
- Package `ball_sched_pkg` holds:
  - state enum;
  - direction bit indices (RIGHT=3, LEFT=2, DOWN=1, UP=0);
  - `ACCEL_CENTER`=256.
- Sub-module `ball_tick_gen`: parameterized divider producing the step tick. It has `clk`, `reset`, and `tick` out.

## Test plan
All cases use `TICK_DIV`=10 and `HOLD_TICKS`=2.
- Reset → all outputs 0. Release reset with `btn_dir`=0 for 100 cycles → `move_out` never asserts, `busy`=0.
- `btn_dir`=0001, `frame_sync` pulsed 3 cycles after the first tick → exactly one `move_out`=0001 pulse, 1 cycle after `frame_sync`.
- Hold `btn_dir`=1000 with `frame_sync` every cycle → pulses issued on ticks 1, 4, 5, 6 (first move, two hold ticks, then one per tick).
- `btn_dir`=1100 → treated as 0, no pulse. `btn_dir`=1001 → diagonal `move_out`=1001.
- No `frame_sync` across 3 ticks with dir held → `drop_cnt`=2; then `frame_sync` → one pulse carrying the latest dir.
- With `BALL_SCHED_ACCEL_EN`, `sel_accel`=1:
  - `accel_x`=300 → right.
  - `accel_x`=288 → none.
  - `accel_y`=200 → up.
- Without the macro, the same stimulus produces no pulses.
